s2p_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares one serial-to-parallel converter among `N_REQ` serial requesters. It grants one requester for exactly one frame of `FRAME_LEN` bits and muxes that requester's bit stream onto the converter's serial input. It tags each frame with its owner index and re-arbitrates after every frame. It sits between the serial sources and the deserializer, which is driven by `ser_valid_o`/`ser_data_o`/`ser_ready_i`.

---
 rtl/s2p_arb_pkg.sv | 14 +
 rtl/s2p_arbiter_if.sv | 36 +++
 rtl/s2p_arbiter_rr_pick.sv | 26 ++
 rtl/s2p_arbiter.sv | 151 +++++++++++++++
 tb/tb_s2p_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/s2p_arb_pkg.sv
// Shared types and width helper for the s2p_arbiter frame sequencer.
package s2p_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of an index/counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/s2p_arbiter_if.sv
// Requester and converter-side signal bundle of the s2p_arbiter.
// master: the arbiter itself; slave: requesters plus deserializer.
interface s2p_arbiter_if
  import s2p_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = cnt_w(N_REQ)
);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] valid_i;
  logic [N_REQ-1:0] data_i;
  logic [N_REQ-1:0] ready_o;
  logic [N_REQ-1:0] gnt_o;
  logic [IDW-1:0]   owner_o;
  logic             busy_o;
  logic             ser_valid_o;
  logic             ser_data_o;
  logic             ser_ready_i;
  logic             frame_done_o;
  logic             frame_abort_o;
  logic             ser_flush_o;

  modport master (
    input  req_i, valid_i, data_i, ser_ready_i,
    output ready_o, gnt_o, owner_o, busy_o, ser_valid_o, ser_data_o,
           frame_done_o, frame_abort_o, ser_flush_o
  );

  modport slave (
    output req_i, valid_i, data_i, ser_ready_i,
    input  ready_o, gnt_o, owner_o, busy_o, ser_valid_o, ser_data_o,
           frame_done_o, frame_abort_o, ser_flush_o
  );

endinterface

// File: rtl/s2p_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester cyclically after last_ptr.
module rr_pick
  import s2p_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = cnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_ptr,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  // Scan from farthest to nearest so the nearest requester after last_ptr wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_ptr) + k) % N_REQ]) begin
        any = 1'b1;
        idx = IDW'((int'(last_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/s2p_arbiter.sv
// Round-robin arbiter sharing one serial-to-parallel converter among N_REQ
// serial sources, one FRAME_LEN-bit frame per grant.
// Optional macro S2P_ARB_TIMEOUT_EN: abort a frame after TIMEOUT cycles in
// which the converter is ready but the owner presents no bit.
module s2p_arbiter
  import s2p_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 6,
  parameter int TIMEOUT   = 16
) (
  input logic         clk,
  input logic         rst,
  s2p_arbiter_if.master bus
);

  localparam int IDW = cnt_w(N_REQ);
  localparam int CW  = cnt_w(FRAME_LEN);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   last_ptr_q, last_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             pick_any;
  logic [IDW-1:0]   pick_idx;
  logic             busy;
  logic             ser_valid;
  logic             beat;

`ifdef S2P_ARB_TIMEOUT_EN
  localparam int SW = cnt_w(TIMEOUT);
  logic [SW-1:0]    stall_q, stall_d;
  logic             abort_q, abort_d;
`else
  logic             unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req      (bus.req_i),
    .last_ptr (last_ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  assign busy      = (state_q == BUSY);
  assign ser_valid = busy & bus.valid_i[owner_q];
  assign beat      = ser_valid & bus.ser_ready_i;

  assign bus.busy_o       = busy;
  assign bus.gnt_o        = gnt_q;
  assign bus.owner_o      = owner_q;
  assign bus.ready_o      = gnt_q & {N_REQ{bus.ser_ready_i}};
  assign bus.ser_valid_o  = ser_valid;
  assign bus.ser_data_o   = bus.data_i[owner_q];
  assign bus.frame_done_o = done_q;
`ifdef S2P_ARB_TIMEOUT_EN
  assign bus.frame_abort_o = abort_q;
  assign bus.ser_flush_o   = abort_q;
`else
  assign bus.frame_abort_o = 1'b0;
  assign bus.ser_flush_o   = 1'b0;
`endif

  // Next-state: grant from IDLE, count beats in BUSY, release after the last beat.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ptr_d = last_ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
`ifdef S2P_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    abort_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
`ifdef S2P_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      BUSY: begin
        if (beat) begin
`ifdef S2P_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            state_d    = IDLE;
            gnt_d      = '0;
            last_ptr_d = owner_q;
            done_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef S2P_ARB_TIMEOUT_EN
        else if (bus.ser_ready_i) begin
          // Converter ready but owner silent: a requester stall.
          if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d    = IDLE;
            gnt_d      = '0;
            last_ptr_d = owner_q;
            abort_d    = 1'b1;
            stall_d    = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; last_ptr resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ptr_q <= IDW'(N_REQ - 1);
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
`ifdef S2P_ARB_TIMEOUT_EN
      stall_q    <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ptr_q <= last_ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
`ifdef S2P_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
      abort_q    <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_s2p_arbiter.sv
// Self-checking bench for s2p_arbiter: directed scenarios followed by a
// randomized phase, all compared against a frame-level reference model.
module tb_s2p_arbiter;
  import s2p_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int FRAME_LEN = 6;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  s2p_arbiter_if #(.N_REQ(N_REQ)) bus ();

  s2p_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the converter, how many bits delivered so far.
  logic       m_busy;
  int         m_owner, m_last, m_cnt, m_stall;
  logic       m_done, m_abort;
  logic [5:0] m_bits, m_frame;

  // Observations of the DUT stream.
  int         dut_beats, last_beat_cyc;
  logic [5:0] dut_bits;
  logic       prev_busy;
  int         g_owner[$];
  int         g_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = N_REQ - 1; m_cnt = 0; m_stall = 0;
    m_done = 1'b0; m_abort = 1'b0; m_bits = '0; m_frame = '0;
  endtask

  // Check current cycle against the model, then advance one clock.
  task automatic tick();
    logic [3:0] eg;
    #2;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", bus.gnt_o, eg);
    chk("owner", bus.owner_o, m_owner);
    chk("busy", bus.busy_o, m_busy);
    chk("ser_valid", bus.ser_valid_o, m_busy & bus.valid_i[m_owner]);
    chk("ready", bus.ready_o, eg & {4{bus.ser_ready_i}});
    chk("frame_done", bus.frame_done_o, m_done);
    chk("frame_abort", bus.frame_abort_o, m_abort);
    chk("ser_flush", bus.ser_flush_o, m_abort);
    if (m_busy && bus.valid_i[m_owner]) chk("ser_data", bus.ser_data_o, bus.data_i[m_owner]);
    // DUT-side frame bookkeeping
    if (bus.frame_done_o) begin
      chk("frame_beats", dut_beats, FRAME_LEN);
      chk("frame_bits", dut_bits, m_frame);
    end
    if (bus.busy_o && !prev_busy) begin
      g_owner.push_back(int'(bus.owner_o));
      g_cyc.push_back(cyc);
    end
    prev_busy = bus.busy_o;
    if (!bus.busy_o) begin dut_beats = 0; dut_bits = '0; end
    if (bus.ser_valid_o && bus.ser_ready_i) begin
      dut_beats++;
      dut_bits = {dut_bits[4:0], bus.ser_data_o};
      last_beat_cyc = cyc;
    end
    // Model advance for the coming edge
    m_done = 1'b0; m_abort = 1'b0;
    if (rst) model_reset();
    else if (!m_busy) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (bus.req_i[(m_last + k) % N_REQ]) begin
          m_owner = (m_last + k) % N_REQ;
          m_busy = 1'b1; m_cnt = 0; m_stall = 0; m_bits = '0;
          break;
        end
      end
    end else if (bus.valid_i[m_owner] && bus.ser_ready_i) begin
      m_bits = {m_bits[4:0], bus.data_i[m_owner]};
      m_cnt++; m_stall = 0;
      if (m_cnt == FRAME_LEN) begin
        m_busy = 1'b0; m_done = 1'b1; m_last = m_owner; m_frame = m_bits;
      end
    end
`ifdef S2P_ARB_TIMEOUT_EN
    else if (bus.ser_ready_i) begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_busy = 1'b0; m_abort = 1'b1; m_last = m_owner;
      end
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0; bus.valid_i = '0; bus.data_i = '0; bus.ser_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.frame_done_o) begin seen = 1'b1; break; end
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    logic [5:0] pat;
    logic       found;
    model_reset();
    dut_beats = 0; dut_bits = '0; prev_busy = 1'b0; last_beat_cyc = 0;

    // Reset state
    do_reset();
    chk("rst_gnt", bus.gnt_o, 4'b0000);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_owner", bus.owner_o, 0);
    chk("rst_done", bus.frame_done_o, 1'b0);

    // Single requester 2, bits 1,0,1,1,0,0
    pat = 6'b101100;
    bus.req_i = 4'b0100; bus.valid_i = 4'b0100; bus.ser_ready_i = 1'b1;
    tick();
    chk("a_gnt", bus.gnt_o, 4'b0100);
    bus.req_i = 4'b0000;
    for (int i = 0; i < FRAME_LEN; i++) begin
      bus.data_i = {1'b0, pat[5-i], 2'b00};
      tick();
    end
    chk("a_done", bus.frame_done_o, 1'b1);
    chk("a_owner", bus.owner_o, 2);
    chk("a_gnt_clr", bus.gnt_o, 4'b0000);
    chk("a_bits", dut_bits, 6'b101100);
    chk("a_beats", dut_beats, FRAME_LEN);
    tick();

    // All four requesting: owners 0,1,2,3,0, one grant every 7 cycles
    do_reset();
    g_owner.delete(); g_cyc.delete();
    bus.req_i = 4'b1111; bus.valid_i = 4'b1111;
    for (int i = 0; i < 32; i++) begin
      bus.data_i = 4'($urandom);
      tick();
    end
    chk("b_grants", (g_owner.size() >= 5), 1'b1);
    if (g_owner.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("b_order", g_owner[i], i % N_REQ);
      for (int i = 1; i < 5; i++) chk("b_period", g_cyc[i] - g_cyc[i-1], FRAME_LEN + 1);
    end

    // Converter stalls 5 cycles mid-frame
    do_reset();
    bus.req_i = 4'b0010; bus.valid_i = 4'b1111; bus.data_i = 4'b0010;
    tick(); tick(); tick();
    bus.req_i = 4'b0000;
    bus.ser_ready_i = 1'b0;
    repeat (5) tick();
    chk("c_busy", bus.busy_o, 1'b1);
    chk("c_beats", dut_beats, 2);
    bus.ser_ready_i = 1'b1;
    wait_done("c_done_wait", 20);
    tick();

    // Owner 0 goes silent after 3 bits while requester 1 waits
    do_reset();
    bus.req_i = 4'b0011; bus.valid_i = 4'b0011; bus.data_i = 4'b0001;
    tick();
    repeat (3) tick();
    bus.valid_i = 4'b0010;
`ifdef S2P_ARB_TIMEOUT_EN
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.frame_abort_o) begin found = 1'b1; break; end
    end
    chk("d_abort_seen", found, 1'b1);
    if (found) begin
      chk("d_abort_delay", cyc - last_beat_cyc, TIMEOUT + 1);
      chk("d_flush", bus.ser_flush_o, 1'b1);
      tick();
      chk("d_next_gnt", bus.gnt_o, 4'b0010);
    end
`else
    found = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.frame_abort_o) found = 1'b1;
    end
    chk("d_no_abort", found, 1'b0);
    chk("d_still_busy", bus.busy_o, 1'b1);
    chk("d_still_owner", bus.owner_o, 0);
    bus.valid_i = 4'b0011;
    wait_done("d_done_wait", 20);
    tick();
    chk("d_next_gnt", bus.gnt_o, 4'b0010);
`endif
    tick();

    // Reset at bit 4, then 0 beats 3 for the first grant
    do_reset();
    bus.req_i = 4'b1000; bus.valid_i = 4'b1000; bus.data_i = 4'b1000;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_gnt", bus.gnt_o, 4'b0000);
    chk("e_busy", bus.busy_o, 1'b0);
    chk("e_owner", bus.owner_o, 0);
    chk("e_done", bus.frame_done_o, 1'b0);
    chk("e_sval", bus.ser_valid_o, 1'b0);
    bus.req_i = 4'b1001; bus.valid_i = 4'b1001;
    tick();
    chk("e_regnt", bus.gnt_o, 4'b0001);

    // Owner drops req after bit 1; frame still runs to completion
    bus.req_i = 4'b0000;
    tick();
    wait_done("f_done_wait", 20);
    chk("f_owner", bus.owner_o, 0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus.req_i = 4'($urandom);
      bus.valid_i = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
      bus.data_i = 4'($urandom);
      bus.ser_ready_i = ($urandom_range(0, 4) != 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
